// File: rtl/water_dispenser_pkg.sv
// Shared types and constants for the water dispenser front-panel controller.
package water_dispenser_pkg;

  typedef enum logic {
    ENTRY      = 1'b0,
    DISPENSING = 1'b1
  } state_t;

  localparam int unsigned DIGIT_COUNT        = 10;
  localparam int unsigned MAX_DIGITS_DEFAULT = 4;
  localparam int unsigned AMOUNT_W           = 14;  // 9999 ml fits
  localparam int unsigned DIGIT_W            = 4;

  // Button lanes; the detector array is indexed with these
  localparam int unsigned NUM_BUTTONS = 3;
  localparam int unsigned BTN_ADD     = 0;
  localparam int unsigned BTN_OK      = 1;
  localparam int unsigned BTN_CANCEL  = 2;

  // One-cycle press events, already edge-detected
  typedef struct packed {
    logic cancel;
    logic ok;
    logic add;
  } btn_evt_t;

endpackage

// File: rtl/water_dispenser_button_press_detector.sv
// Active-low pushbutton: 2-FF synchronizer followed by a falling-edge pulse.
// The pulse is combinational off the synchronized history so the consuming
// register updates on the third clock edge after the pin falls.
module button_press_detector (
  input  logic clock,
  input  logic reset,
  input  logic button_n,
  output logic press
);

  // sync_pipe[0]: first sync stage, [1]: second sync stage, [2]: previous
  // synchronized level used for edge detection. Released level is 1.
  logic [2:0] sync_pipe;

  // Shift the raw pin through the synchronizer and history stage
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_pipe <= '1;
    else       sync_pipe <= {sync_pipe[1:0], button_n};
  end

  // High for exactly one cycle per 1->0 transition; holding repeats nothing
  assign press = sync_pipe[2] & ~sync_pipe[1];

endmodule

// File: rtl/water_dispenser.sv
// Water dispenser controller: decimal volume entry from one-hot switches,
// confirmation, then a timed dispense proportional to the volume.
module water_dispenser
  import water_dispenser_pkg::*;
#(
  parameter int unsigned NS_PER_ML       = 1000,
  parameter int unsigned CLOCK_PERIOD_NS = 20,
  parameter int unsigned MAX_DIGITS      = MAX_DIGITS_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DIGIT_COUNT-1:0] switches,
  input  logic                   button_add,
  input  logic                   button_ok,
  input  logic                   button_cancel,
  output logic                   current_state,
  output logic [31:0]            total_amount_in_ml
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  logic [NUM_BUTTONS-1:0] btn_n;
  logic [NUM_BUTTONS-1:0] press;
  btn_evt_t               evt;

  state_t                 state, state_nx;
  logic [AMOUNT_W-1:0]    amount, amount_nx;
  logic [CNT_W-1:0]       digit_count, count_nx;
  logic [31:0]            elapsed, elapsed_nx;

  logic                   digit_vld;
  logic [DIGIT_W-1:0]     digit;
  logic [AMOUNT_W-1:0]    amount_app;
  logic [31:0]            target_ns;
  logic [31:0]            elapsed_inc;

  assign btn_n[BTN_ADD]    = button_add;
  assign btn_n[BTN_OK]     = button_ok;
  assign btn_n[BTN_CANCEL] = button_cancel;

  // One detector per button lane
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_press_detector u_det (
      .clock    (clock),
      .reset    (reset),
      .button_n (btn_n[i]),
      .press    (press[i])
    );
  end

  assign evt.add    = press[BTN_ADD];
  assign evt.ok     = press[BTN_OK];
  assign evt.cancel = press[BTN_CANCEL];

  // Priority encoder: lowest-index set switch wins
  always_comb begin
    digit_vld = 1'b0;
    digit     = '0;
    for (int d = DIGIT_COUNT - 1; d >= 0; d--) begin
      if (switches[d]) begin
        digit_vld = 1'b1;
        digit     = DIGIT_W'(d);
      end
    end
  end

  // Datapath helpers, all in 32 bits so the dispense compare cannot wrap
  assign amount_app  = AMOUNT_W'(32'(amount) * 32'd10 + 32'(digit));
  assign target_ns   = 32'(amount) * NS_PER_ML;
  assign elapsed_inc = elapsed + CLOCK_PERIOD_NS;

  // State, amount, digit counter and dispense timer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ENTRY;
      amount      <= '0;
      digit_count <= '0;
      elapsed     <= '0;
    end else begin
      state       <= state_nx;
      amount      <= amount_nx;
      digit_count <= count_nx;
      elapsed     <= elapsed_nx;
    end
  end

  // Next-state logic; in ENTRY cancel beats ok beats add
  always_comb begin
    state_nx   = state;
    amount_nx  = amount;
    count_nx   = digit_count;
    elapsed_nx = elapsed;
    unique case (state)
      ENTRY: begin
        if (evt.cancel) begin
          amount_nx = '0;
          count_nx  = '0;
        end else if (evt.ok) begin
          // A zero entry never starts a dispense, but the digits are consumed
          count_nx = '0;
          if (amount != '0) begin
            state_nx   = DISPENSING;
            elapsed_nx = '0;
          end
        end else if (evt.add && digit_vld && (digit_count < CNT_W'(MAX_DIGITS))) begin
          amount_nx = amount_app;
          count_nx  = digit_count + CNT_W'(1);
        end
      end
      DISPENSING: begin
        // add and ok are dropped here; only cancel or timeout leave
        if (evt.cancel || (elapsed_inc >= target_ns)) begin
          state_nx   = ENTRY;
          amount_nx  = '0;
          count_nx   = '0;
          elapsed_nx = '0;
        end else begin
          elapsed_nx = elapsed_inc;
        end
      end
      default: begin
        state_nx   = ENTRY;
        amount_nx  = '0;
        count_nx   = '0;
        elapsed_nx = '0;
      end
    endcase
  end

  assign current_state      = state;
  assign total_amount_in_ml = 32'(amount);

endmodule

// File: tb/tb_water_dispenser.sv
// Scoreboard bench: a volume-level reference model pushes the expected panel
// outputs after every clock edge; a negedge monitor pops and compares.
module tb_water_dispenser;

  localparam int NS  = 1;
  localparam int CP  = 20;
  localparam int MAXD = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  switches = '0;
  logic        button_add = 1'b1;
  logic        button_ok = 1'b1;
  logic        button_cancel = 1'b1;
  logic        current_state;
  logic [31:0] total_amount_in_ml;

  water_dispenser #(.NS_PER_ML(NS), .CLOCK_PERIOD_NS(CP), .MAX_DIGITS(MAXD)) dut (
    .clock              (clock),
    .reset              (reset),
    .switches           (switches),
    .button_add         (button_add),
    .button_ok          (button_ok),
    .button_cancel      (button_cancel),
    .current_state      (current_state),
    .total_amount_in_ml (total_amount_in_ml)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic        st;
    logic [31:0] amt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: volume as an integer, dispense as a remaining-cycle count
  bit       m_disp;
  int       m_amt, m_dig, m_rem;
  bit [3:0] ha, ho, hc;   // per-edge pin samples, [0] newest

  function automatic void model_reset();
    m_disp = 0; m_amt = 0; m_dig = 0; m_rem = 0;
    ha = '1; ho = '1; hc = '1;
  endfunction

  function automatic int lowest(input logic [9:0] sw);
    for (int d = 0; d < 10; d++) if (sw[d]) return d;
    return -1;
  endfunction

  function automatic void model_edge();
    bit ea, eo, ec;
    int d;
    if (reset) begin model_reset(); return; end
    ha = {ha[2:0], button_add};
    ho = {ho[2:0], button_ok};
    hc = {hc[2:0], button_cancel};
    // a press acts three edges after the pin is first seen low
    ea = (ha[3] == 1'b1) && (ha[2] == 1'b0);
    eo = (ho[3] == 1'b1) && (ho[2] == 1'b0);
    ec = (hc[3] == 1'b1) && (hc[2] == 1'b0);
    if (m_disp) begin
      if (ec) begin m_disp = 0; m_amt = 0; m_dig = 0; end
      else begin
        m_rem--;
        if (m_rem == 0) begin m_disp = 0; m_amt = 0; m_dig = 0; end
      end
    end else if (ec) begin
      m_amt = 0; m_dig = 0;
    end else if (eo) begin
      m_dig = 0;
      if (m_amt > 0) begin
        m_disp = 1;
        m_rem  = (m_amt * NS + CP - 1) / CP;
      end
    end else if (ea) begin
      d = lowest(switches);
      if (d >= 0 && m_dig < MAXD) begin
        m_amt = m_amt * 10 + d;
        m_dig++;
      end
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      model_edge();
      exp_q.push_back('{st: m_disp, amt: 32'(m_amt)});
      #1;
    end
  endtask

  // mask bit0 add, bit1 ok, bit2 cancel
  task automatic press(input int mask, input int hold, input int gap);
    if (mask[0]) button_add = 1'b0;
    if (mask[1]) button_ok = 1'b0;
    if (mask[2]) button_cancel = 1'b0;
    step(hold);
    button_add = 1'b1; button_ok = 1'b1; button_cancel = 1'b1;
    step(gap);
  endtask

  task automatic add_digit(input int d);
    logic [9:0] one;
    one = 10'd1;
    switches = one << d;
    press(1, 2, 2);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Asynchronous reset placed after a monitor sample so no pending compare sees it
  task automatic async_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_now("async_reset_state", 32'(current_state), 32'd0);
    check_now("async_reset_amount", total_amount_in_ml, 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Monitor: outputs are presented every cycle; compare against queued expectations
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 2;
      if (current_state !== e.st) begin
        errors++;
        $display("FAIL state @%0t: got %0d expected %0d", $time, current_state, e.st);
      end
      if (total_amount_in_ml !== e.amt) begin
        errors++;
        $display("FAIL amount @%0t: got %0d expected %0d", $time, total_amount_in_ml, e.amt);
      end
    end
  end

  initial begin
    int op, n;
    model_reset();
    #5;
    check_now("reset_state", 32'(current_state), 32'd0);
    check_now("reset_amount", total_amount_in_ml, 32'd0);
    step(2);
    reset = 1'b0;
    step(2);

    // Digit limit: 3,1,9,0 then 6,4 ignored; cancel
    add_digit(3); add_digit(1); add_digit(9); add_digit(0);
    add_digit(6); add_digit(4);
    press(4, 2, 3);

    // Multi-hot switches: lowest bit wins
    switches = 10'b01_0100_1000; press(1, 2, 2);
    switches = 10'b10_0010_0001; press(1, 2, 2);
    press(4, 2, 3);

    // ok on zero entry clears digit count
    add_digit(0); add_digit(0);
    press(2, 2, 3);
    add_digit(6); add_digit(4); add_digit(0);
    // dispense 640 to completion, then again and cancel mid-way
    press(2, 2, 40);
    add_digit(6); add_digit(4); add_digit(0);
    press(2, 2, 12);
    press(4, 2, 4);

    // ignored add/ok during dispense of 1380
    add_digit(1); add_digit(3); add_digit(8); add_digit(0);
    press(2, 2, 6);
    add_digit(8); add_digit(0);
    press(2, 2, 70);

    // held add appends once; coincident buttons
    switches = 10'b00_0010_0000;
    press(1, 40, 3);
    switches = 10'b00_0000_0100;
    press(3, 2, 3);
    press(7, 2, 3);
    press(5, 2, 3);

    // reset mid-entry and mid-dispense
    add_digit(7);
    async_reset();
    add_digit(9); add_digit(9);
    press(2, 2, 3);
    async_reset();

    // Randomized operation mix
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 15);
      if (op <= 8) begin
        switches = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
        press(1, $urandom_range(1, 4), $urandom_range(1, 3));
      end else if (op <= 10) begin
        press(2, $urandom_range(1, 3), $urandom_range(1, 3));
      end else if (op == 11) begin
        press(4, $urandom_range(1, 3), $urandom_range(1, 3));
      end else if (op == 12) begin
        switches = 10'($urandom);
        press($urandom_range(1, 7), $urandom_range(1, 3), $urandom_range(1, 3));
      end else if (op == 13 && i % 50 == 7) begin
        async_reset();
      end else begin
        n = $urandom_range(1, 60);
        step(n);
      end
    end
    step(600);
    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/water_dispenser.md
Name: water_dispenser

Overview:
- Controller for a water dispenser front panel.
- The user builds a decimal volume (ml) digit by digit with ten one-hot switches and an "add" button, then confirms with "ok".
- The block then runs a timed dispense whose duration is proportional to the volume.
- Sits between debounced-enough panel inputs (switches, active-low pushbuttons) and the valve/display logic.

Parameters:
- NS_PER_ML, default 1000: dispense time per ml, in ns.
- CLOCK_PERIOD_NS, default 20: clock period in ns (50 MHz).
- MAX_DIGITS, default 4: maximum number of digits accepted per entry.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- switches  in  10  digit selectors; bit d high selects digit d.
- button_add  in  1  active-low; append the selected digit.
- button_ok  in  1  active-low; confirm the entry and start dispensing.
- button_cancel  in  1  active-low; clear the entry, or abort a dispense.
- current_state  out  1  0 = ENTRY, 1 = DISPENSING.
- total_amount_in_ml  out  32  current entered or dispensing volume, unsigned integer.

Behaviour:
- Reset (async, high): state = ENTRY, total_amount_in_ml = 0, digit_count = 0, dispense timer = 0, edge-detect history = released (1).
- Buttons:
  - Each button passes through a 2-FF synchronizer, then falling-edge detection.
  - An action happens exactly once per press (1→0 transition). Holding a button repeats nothing.
  - Latency from pin falling edge to register update: 3 clock edges.
- Digit selection:
  - On an add event, the digit is the lowest-index set bit of switches, sampled in the same cycle as the event.
  - switches == 0 → add ignored.
- ENTRY state:
  - add, with a valid digit and digit_count < MAX_DIGITS: amount = amount*10 + digit; digit_count += 1. Leading zeros count as digits.
  - add with digit_count == MAX_DIGITS: ignored; amount unchanged.
  - cancel: amount = 0, digit_count = 0.
  - ok with amount > 0: go to DISPENSING; elapsed_ns = 0; digit_count = 0.
  - ok with amount == 0: stay in ENTRY; digit_count = 0 (no 0 ml dispense).
  - Priority when events coincide in one cycle: cancel > ok > add.
- DISPENSING state:
  - Each cycle elapsed_ns += CLOCK_PERIOD_NS.
  - When elapsed_ns >= amount*NS_PER_ML: go to ENTRY, amount = 0, digit_count = 0.
  - Dispense duration = ceil(amount*NS_PER_ML / CLOCK_PERIOD_NS) cycles.
  - total_amount_in_ml holds the confirmed amount for the whole dispense.
  - add and ok events are ignored (discarded, not queued).
  - cancel aborts: go to ENTRY, amount = 0, digit_count = 0.
- Width and arithmetic:
  - Amount ≤ 9999 fits in 14 bits; output zero-extended to 32 bits.
  - amount*NS_PER_ML and elapsed_ns are computed in 32 bits and never overflow for the defaults.
- current_state is registered and changes on the clock edge that performs the transition.
- Reset mid-dispense: immediate return to ENTRY with amount 0.

Decomposition:
- Package water_dispenser_pkg:
  - state enum {ENTRY=1'b0, DISPENSING=1'b1}
  - DIGIT_COUNT=10
  - MAX_DIGITS default
  - amount width constant (14)
- Sub-module button_press_detector (per button): 2-FF synchronizer + falling-edge pulse. Instantiated three times.
- Priority encoder (lowest set bit) and FSM/datapath stay in the top module.

Test Plan:
- NS_PER_ML=1, 20 ns clock. Add digits 3,1,9,0 then 6,4 → amount 3190 (5th/6th digits ignored); cancel → 0, state 0.
- Switches 8,3,6 held together + add → digit 3. Then 9,5,0 together + add → digit 0. Amount 30; cancel → 0.
- Digits 0,0 then ok → state stays 0, amount 0. Then digits 6,4,0 → amount 640 (proves digit_count was cleared by ok).
- Ok at 640 → state 1 for 32 cycles, amount 640 held, then state 0 and amount 0. A cancel 12 cycles into the dispense → immediate state 0, amount 0.
- Enter 1,3,8,0 + ok → state 1. During the dispense, add 8, add 0 and ok → ignored. Amount stays 1380; returns to 0 after 69 cycles total.
- Assert reset mid-entry and mid-dispense → outputs 0 asynchronously. Holding button_add low for many cycles → exactly one digit appended.
